btn_pulse_gen: RTL



---
 rtl/btn_pulse_gen_pkg.sv | 27 ++
 rtl/btn_channel.sv | 123 ++++++++++++
 rtl/btn_pulse_gen.sv | 34 +++
 3 files changed

// File: rtl/btn_pulse_gen_pkg.sv
// Shared constants for the push-button conditioner: button indices, default
// cycle counts at the 100 MHz mclk, and the per-channel state encoding.
package btn_pulse_gen_pkg;

    localparam int BTN_TENS  = 0;
    localparam int BTN_UNITS = 1;
    localparam int BTN_NEXT  = 2;

    localparam int MCLK_HZ              = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DFLT = MCLK_HZ / 50;  // 20 ms
    localparam int REPEAT_DELAY_DFLT    = MCLK_HZ / 2;   // 500 ms
    localparam int REPEAT_PERIOD_DFLT   = MCLK_HZ / 5;   // 200 ms

    // Digit buttons auto-repeat; the field-advance button never does.
    localparam logic [2:0] REPEAT_MASK_DFLT = 3'((1 << BTN_TENS) | (1 << BTN_UNITS));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, stable-sample debounce, and the
// press / auto-repeat strobe FSM.
module btn_channel
    import btn_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DFLT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DFLT,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int DW = max_int(1, $clog2(DEBOUNCE_CYCLES + 1));
    localparam int RW = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)));

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    btn_state_e    state_q, state_d;

    logic s;
    logic rise;
    logic fall;

    assign s = sync_q[1];

    // Debounce: any sample matching the accepted level restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        dcnt_d  = '0;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s != level_q) begin
            if (dcnt_q == D_LAST) begin
                level_d = s;
                rise    = s;
                fall    = ~s;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    // Strobe FSM keys off the level update itself, so the press pulse and
    // the first high level cycle coincide. Release wins over a repeat.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == RD_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (rcnt_q == RP_LAST) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            rcnt_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner for the time/date/alarm set logic: one independent
// btn_channel per button, each turning a bouncing pin into one-cycle strobes.
module btn_pulse_gen
    import btn_pulse_gen_pkg::*;
#(
    parameter int               N_BTN           = 3,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DFLT,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DFLT,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DFLT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .level   (level[i]),
            .pulse   (pulse[i])
        );
    end

endmodule
